// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshake and the data_memory port of the load/store unit.
// The slave modport is the LSU's view; the master modport belongs to the core plus memory that surround it.
interface load_store_unit_if #(
    parameter int W = 32,
    parameter int N = 5
) ();
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [N+1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_rdata;
    logic         resp_err;
    logic [N-1:0] address;
    logic         MemRead;
    logic         MemWrite;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output address, MemRead, MemWrite, write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  address, MemRead, MemWrite, write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory: extends loads and read-modify-writes sub-word stores.
// Response 1 (error), 2 (word store), 3 (load) or 4 (sub-word store) cycles after accept; one request in flight, response held until resp_ready.
module load_store_unit #(
    parameter int W = 32,
    parameter int N = 5
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic         we_q, we_d;
    logic [1:0]   size_q, size_d;
    logic         uns_q, uns_d;
    logic [N+1:0] addr_q, addr_d;
    logic [15:0]  wdata_q, wdata_d;
    logic [W-1:0] wrdat_q, wrdat_d;
    logic [W-1:0] rdata_q, rdata_d;
    logic         err_q, err_d;

    logic         req_bad;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;
    logic [W-1:0] ld_ext;
    logic [W-1:0] st_merge;

    // Alignment is judged on the live request, so an error never touches memory.
    always_comb begin
        req_bad = 1'b0;
        case (bus.req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = bus.req_addr[0];
            2'b10:   req_bad = |bus.req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = bus.read_data[7:0];
        case (addr_q[1:0])
            2'd0:    ld_byte = bus.read_data[7:0];
            2'd1:    ld_byte = bus.read_data[15:8];
            2'd2:    ld_byte = bus.read_data[23:16];
            default: ld_byte = bus.read_data[31:24];
        endcase
        ld_half = addr_q[1] ? bus.read_data[31:16] : bus.read_data[15:0];

        ld_ext = bus.read_data;
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus.read_data;
        endcase

        // Sub-word store: splice the new lane into the word just read back.
        st_merge = bus.read_data;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    st_merge[7:0]   = wdata_q[7:0];
                2'd1:    st_merge[15:8]  = wdata_q[7:0];
                2'd2:    st_merge[23:16] = wdata_q[7:0];
                default: st_merge[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) st_merge[31:16] = wdata_q;
            else           st_merge[15:0]  = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wrdat_d = wrdat_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata[15:0];
                    rdata_d = '0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (bus.req_we && bus.req_size == 2'b10) begin
                        wrdat_d = bus.req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (we_q) begin
                    wrdat_d = st_merge;
                    state_d = S_WR;
                end else begin
                    rdata_d = ld_ext;
                    state_d = S_RESP;
                end
            end
            S_WR: state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wrdat_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wrdat_q <= wrdat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes come straight from the state register, never from inputs.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.MemRead    = (state_q == S_RD);
    assign bus.MemWrite   = (state_q == S_WR);
    assign bus.address    = addr_q[N+1:2];
    assign bus.write_data = wrdat_q;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked against a byte-array memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.W(32), .N(5)) bus ();
    load_store_unit #(.W(32), .N(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Word-addressed data_memory with one-cycle registered read.
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (bus.MemWrite) begin
            mem[bus.address] <= bus.write_data;
        end
        if (bus.MemRead) bus.read_data <= mem[bus.address];
    end

    // Reference model: memory as a flat little-endian byte array.
    logic [7:0] ref_b [0:127];

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns, input logic [6:0] a);
        int     nb;
        longint v;
        nb = 1 << size;
        v  = 0;
        for (int i = 0; i < nb; i++) v = v | (longint'(ref_b[int'(a) + i]) << (8 * i));
        if (!uns && v[8 * nb - 1]) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_word(input int wi);
        return {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]};
    endfunction

    task automatic m_store(input logic [1:0] size, input logic [6:0] a, input logic [31:0] wd);
        int nb;
        nb = 1 << size;
        for (int i = 0; i < nb; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
    endtask

    function automatic bit m_err(input logic [1:0] size, input logic [6:0] a);
        return (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic int m_lat(input logic we, input logic [1:0] size, input logic [6:0] a);
        if (m_err(size, a)) return 1;
        if (!we) return 3;
        return (size == 2'd2) ? 2 : 4;
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [4:0]  waddr;
        logic [31:0] wdat;
        bit          stable;
        bit          rdy_low;
        bit          post_idle;
    } obs_t;

    // Drives one request, observes it through the response handshake.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns, input logic [6:0] a,
                        input logic [31:0] wd, input int hold, input bit keep, output obs_t o);
        int g;
        o.rdata = '0; o.err = 1'b0; o.lat = -1; o.nrd = 0; o.nwr = 0;
        o.waddr = '0; o.wdat = '0; o.stable = 1'b1; o.rdy_low = 1'b1; o.post_idle = 1'b0;
        @(negedge clk);
        g = 0;
        while (bus.req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (keep) begin
            bus.req_we = ~we; bus.req_unsigned = ~uns;
            bus.req_size = 2'($urandom_range(0, 3));
            bus.req_addr = 7'($urandom_range(0, 127));
            bus.req_wdata = $urandom;
        end else begin
            bus.req_valid = 1'b0;
        end
        g = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.MemRead === 1'b1) o.nrd++;
            if (bus.MemWrite === 1'b1) begin o.nwr++; o.waddr = bus.address; o.wdat = bus.write_data; end
            if (bus.req_ready !== 1'b0) o.rdy_low = 1'b0;
            if (bus.resp_valid === 1'b1) begin o.lat = g; break; end
            g++;
        end
        o.rdata = bus.resp_rdata;
        o.err   = bus.resp_err;
        repeat (hold) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== o.rdata ||
                bus.resp_err !== o.err || bus.req_ready !== 1'b0) o.stable = 1'b0;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        o.post_idle = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1) &&
                      (bus.resp_err === 1'b0) && (bus.resp_rdata === 32'h0);
    endtask

    task automatic test_reset();
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        for (int i = 0; i < 128; i++) ref_b[i] = 8'h00;
        rst = 1'b0; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b want 10000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.MemRead, bus.MemWrite});
        else n_pass++;
        n_chk++;
        if (bus.resp_rdata !== 32'h0 || bus.address !== 5'h0 || bus.write_data !== 32'h0)
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want zeros",
                     bus.resp_rdata, bus.address, bus.write_data);
        else n_pass++;
    endtask

    task automatic test_word_store_load();
        obs_t o;
        xact(1'b1, 2'd2, 1'b0, 7'h10, 32'hDEADBEEF, 0, 1'b0, o);
        m_store(2'd2, 7'h10, 32'hDEADBEEF);
        n_chk++; if (o.nwr !== 1 || o.nrd !== 0) $display("FAIL wst_strobes: got rd=%0d wr=%0d want 0/1", o.nrd, o.nwr); else n_pass++;
        n_chk++; if (o.waddr !== 5'd4 || o.wdat !== 32'hDEADBEEF) $display("FAIL wst_bus: got %h/%h want 04/deadbeef", o.waddr, o.wdat); else n_pass++;
        n_chk++; if (o.lat !== 2 || o.err !== 1'b0) $display("FAIL wst_resp: got lat=%0d err=%b want 2/0", o.lat, o.err); else n_pass++;
        n_chk++; if (o.post_idle !== 1'b1) $display("FAIL wst_post: got %b want 1", o.post_idle); else n_pass++;
        xact(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 0, 1'b0, o);
        n_chk++; if (o.rdata !== 32'hDEADBEEF) $display("FAIL wld_data: got %h want deadbeef", o.rdata); else n_pass++;
        n_chk++; if (o.lat !== 3 || o.nrd !== 1 || o.nwr !== 0) $display("FAIL wld_timing: got lat=%0d rd=%0d wr=%0d want 3/1/0", o.lat, o.nrd, o.nwr); else n_pass++;
    endtask

    task automatic test_subword_loads();
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [6:0]  ad  [4] = '{7'h13, 7'h13, 7'h10, 7'h12};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFFFEF, 32'hFFFFDEAD};
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, sz[i], un[i], ad[i], 32'h0, 0, 1'b0, o);
            n_chk++;
            if (o.rdata !== exp[i] || o.lat !== 3)
                $display("FAIL subld_%0d: got %h lat=%0d want %h lat=3", i, o.rdata, o.lat, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_subword_store();
        obs_t o;
        xact(1'b1, 2'd0, 1'b0, 7'h11, 32'hAAAAAA55, 0, 1'b0, o);
        m_store(2'd0, 7'h11, 32'hAAAAAA55);
        n_chk++; if (o.nrd !== 1 || o.nwr !== 1) $display("FAIL sbst_strobes: got rd=%0d wr=%0d want 1/1", o.nrd, o.nwr); else n_pass++;
        n_chk++; if (o.wdat !== 32'hDEAD55EF || o.waddr !== 5'd4) $display("FAIL sbst_merge: got %h@%h want dead55ef@04", o.wdat, o.waddr); else n_pass++;
        n_chk++; if (o.lat !== 4 || o.rdata !== 32'h0) $display("FAIL sbst_resp: got lat=%0d rdata=%h want 4/0", o.lat, o.rdata); else n_pass++;
        xact(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 0, 1'b0, o);
        n_chk++; if (o.rdata !== 32'hDEAD55EF) $display("FAIL sbst_readback: got %h want dead55ef", o.rdata); else n_pass++;
        xact(1'b1, 2'd1, 1'b0, 7'h12, 32'hFFFF1234, 0, 1'b0, o);
        m_store(2'd1, 7'h12, 32'hFFFF1234);
        n_chk++; if (o.wdat !== 32'h123455EF || o.lat !== 4) $display("FAIL hst_merge: got %h lat=%0d want 123455ef lat=4", o.wdat, o.lat); else n_pass++;
    endtask

    task automatic test_errors();
        logic [1:0] sz [3] = '{2'd2, 2'd1, 2'd3};
        logic [6:0] ad [3] = '{7'h02, 7'h01, 7'h10};
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            xact(i[0], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, 0, 1'b0, o);
            n_chk++;
            if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.lat !== 1)
                $display("FAIL err_%0d_resp: got err=%b rdata=%h lat=%0d want 1/0/1", i, o.err, o.rdata, o.lat);
            else n_pass++;
            n_chk++;
            if (o.nrd !== 0 || o.nwr !== 0) $display("FAIL err_%0d_mem: got rd=%0d wr=%0d want 0/0", i, o.nrd, o.nwr); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        xact(1'b0, 2'd1, 1'b1, 7'h12, 32'h0, 5, 1'b1, o);
        n_chk++; if (o.stable !== 1'b1) $display("FAIL bp_stable: got %b want 1", o.stable); else n_pass++;
        n_chk++; if (o.rdy_low !== 1'b1) $display("FAIL bp_req_ready: got %b want 1 (low while busy)", o.rdy_low); else n_pass++;
        n_chk++; if (o.rdata !== m_load(2'd1, 1'b1, 7'h12)) $display("FAIL bp_data: got %h want %h", o.rdata, m_load(2'd1, 1'b1, 7'h12)); else n_pass++;
        n_chk++; if (o.post_idle !== 1'b1) $display("FAIL bp_post: got %b want 1", o.post_idle); else n_pass++;
        xact(1'b0, 2'd0, 1'b0, 7'h10, 32'h0, 0, 1'b0, o);
        n_chk++; if (o.lat !== 3 || o.rdata !== m_load(2'd0, 1'b0, 7'h10)) $display("FAIL bp_next: got %h lat=%0d want %h lat=3", o.rdata, o.lat, m_load(2'd0, 1'b0, 7'h10)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 7'h1C; bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_chk++; if (bus.MemWrite !== 1'b1) $display("FAIL rmid_in_wr: got %b want 1", bus.MemWrite); else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++; if (bus.MemWrite !== 1'b0 || bus.write_data !== 32'h0) $display("FAIL rmid_async: got we=%b wd=%h want 0/0", bus.MemWrite, bus.write_data); else n_pass++;
        @(posedge clk);
        #1;
        n_chk++; if (mem[7] !== 32'h0) $display("FAIL rmid_nocommit: got %h want 0", mem[7]); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
                $display("FAIL rmid_after: got ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid);
            else n_pass++;
        end
        xact(1'b0, 2'd2, 1'b0, 7'h1C, 32'h0, 0, 1'b0, o);
        n_chk++; if (o.rdata !== m_word(7)) $display("FAIL rmid_readback: got %h want %h", o.rdata, m_word(7)); else n_pass++;
    endtask

    task automatic test_top_word();
        obs_t o;
        xact(1'b1, 2'd2, 1'b0, 7'h7C, 32'h87654321, 0, 1'b0, o);
        m_store(2'd2, 7'h7C, 32'h87654321);
        n_chk++; if (o.err !== 1'b0 || o.waddr !== 5'd31) $display("FAIL top_store: got err=%b addr=%h want 0/1f", o.err, o.waddr); else n_pass++;
        xact(1'b0, 2'd0, 1'b0, 7'h7F, 32'h0, 0, 1'b0, o);
        n_chk++; if (o.rdata !== m_load(2'd0, 1'b0, 7'h7F)) $display("FAIL top_load: got %h want %h", o.rdata, m_load(2'd0, 1'b0, 7'h7F)); else n_pass++;
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we, uns, e;
        logic [1:0]  sz;
        logic [6:0]  a;
        logic [31:0] wd, exp;
        for (int t = 0; t < 60; t++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~7'((1 << sz) - 1);
            wd  = $urandom;
            e   = m_err(sz, a);
            xact(we, sz, uns, a, wd, $urandom_range(0, 2), 1'($urandom_range(0, 1)), o);
            exp = '0;
            if (!e && !we) exp = m_load(sz, uns, a);
            if (!e && we) m_store(sz, a, wd);
            n_chk++;
            if (o.err !== e || o.rdata !== exp || o.lat !== m_lat(we, sz, a))
                $display("FAIL rnd_%0d_resp: got err=%b rdata=%h lat=%0d want %b/%h/%0d",
                         t, o.err, o.rdata, o.lat, e, exp, m_lat(we, sz, a));
            else n_pass++;
            if (!e && we) begin
                n_chk++;
                if (o.nwr !== 1 || o.waddr !== a[6:2] || o.wdat !== m_word(int'(a[6:2])))
                    $display("FAIL rnd_%0d_write: got n=%0d %h@%h want 1 %h@%h",
                             t, o.nwr, o.wdat, o.waddr, m_word(int'(a[6:2])), a[6:2]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sweep();
        obs_t o;
        for (int w = 0; w < 32; w++) begin
            xact(1'b0, 2'd2, 1'b0, 7'(w * 4), 32'h0, 0, 1'b0, o);
            n_chk++;
            if (o.rdata !== m_word(w)) $display("FAIL sweep_w%0d: got %h want %h", w, o.rdata, m_word(w));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_loads();
        test_subword_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_top_word();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data_memory port: drives address, MemRead, MemWrite and write_data; captures read_data.
- Sits between the core's memory pipeline stage and the word-addressed data_memory.
- Converts byte-addressed load/store requests (byte, half, word) into word accesses, with valid/ready handshakes on both the request and response sides.
- Performs sign/zero extension on loads, read-modify-write for sub-word stores, and alignment checking.

Parameters:
- W, 32, data word width; only 32 is supported (4 byte lanes).
- N, 5, word-address width of data_memory; depth is 2^N words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  N+2  byte address.
- req_wdata  in  W  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.
- address  out  N  word address to data_memory.
- MemRead  out  1  read enable to data_memory.
- MemWrite  out  1  write enable to data_memory.
- write_data  out  W  write data to data_memory.
- read_data  in  W  read data from data_memory.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - req_ready=1 once released; resp_valid=0, resp_err=0, resp_rdata=0.
  - MemRead=0, MemWrite=0, address=0, write_data=0; internal latches cleared.
- Memory timing contract: read_data is valid in the cycle after MemRead is asserted with a stable address. A write commits on the rising edge at which MemWrite=1.
- FSM states: IDLE, RD, CAP, WR, RESP.
- Output decoding:
  - MemRead=1 only in RD; MemWrite=1 only in WR.
  - Both are decoded from the state register only, with no combinational path from inputs.
  - req_ready=1 only in IDLE.
- Accept: in IDLE with req_valid=1, latch we, size, unsigned, addr and wdata. address = addr[N+1:2], held until RESP.
- Alignment error (checked at accept): size=11, half with addr[0]=1, or word with addr[1:0]!=00.
  - Go to RESP with resp_err=1 and resp_rdata=0.
  - No memory access.
- Load: IDLE -> RD -> CAP -> RESP.
  - In CAP, select the lane from addr[1:0] (byte) or addr[1] (half), extend per unsigned, and register into resp_rdata.
  - resp_valid rises 3 cycles after the accept edge.
- Word store: IDLE -> WR -> RESP.
  - write_data = wdata.
  - resp_valid rises 2 cycles after accept.
- Sub-word store: IDLE -> RD -> CAP -> WR -> RESP.
  - In CAP, merge the wdata low byte/half into the selected lane of read_data; other lanes are preserved.
  - resp_valid rises 4 cycles after accept.
- RESP handling:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1.
  - On the handshake edge, go to IDLE, clear resp_valid and resp_err, and set resp_rdata=0.
  - No back-to-back overlap: a new request is accepted only in IDLE, the cycle after the response handshake.
- Inputs changing after accept are ignored. read_data is ignored outside CAP.
- Reset mid-operation: all outputs clear immediately. A WR-state write is not committed if rst is low at the edge. No response is produced for the aborted request.
- Address wrap: none. addr spans exactly 2^N words; the top word (addr = 2^(N+2)-4) is legal.

Test Plan:
- Word store then load:
  - store addr=0x10 (word 4), wdata=0xDEADBEEF -> MemWrite high exactly 1 cycle with address=4, write_data=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0.
  - load word addr=0x10 -> resp_rdata=0xDEADBEEF 3 cycles after accept.
- Byte loads from word 4=0xDEADBEEF:
  - addr=0x13 signed -> 0xFFFFFFDE.
  - addr=0x13 unsigned -> 0x000000DE.
  - addr=0x10 signed -> 0xFFFFFFEF.
  - half addr=0x12 signed -> 0xFFFFDEAD.
- Sub-word stores:
  - byte store addr=0x11, wdata=0x55 -> MemRead then MemWrite with write_data=0xDEAD55EF; later word load returns 0xDEAD55EF.
  - half store addr=0x12, wdata=0x1234 -> memory word becomes 0x123455EF.
- Errors:
  - word at 0x02, half at 0x01, size=11 -> resp_err=1, resp_rdata=0, MemRead and MemWrite never asserted, resp 1 cycle after accept.
- Backpressure:
  - hold resp_ready=0 for 5 cycles after a load -> resp_valid, resp_rdata and resp_err stable.
  - req_ready=0 throughout while req_valid held high; next request accepted only after the handshake.
- Reset mid-operation:
  - assert rst=0 during WR of a store to word 7 (previously 0x0) -> MemWrite drops asynchronously, word 7 still 0x0.
  - after release, req_ready=1 and resp_valid=0.
